// File: rtl/ram_burst_controller.sv
// Single-port RAM front end: accepts one read/write burst at a time and auto-increments the address per beat.
// Read data is registered one cycle after issue; write beats stall on wr_valid=0, reads never stall.
module ram_burst_controller #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int BURST_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [BURST_WIDTH-1:0] req_len,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_last,
  output logic                   reading,
  output logic                   writing
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [BURST_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  ram [DEPTH];

  logic write_beat;
  logic read_beat;
  logic last_beat;

  assign write_beat = (state == WRITE) && wr_valid;
  assign read_beat  = (state == READ);
  assign last_beat  = (cnt == '0);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid && last_beat) begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        if (last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from state
  always_comb begin
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    writing   = 1'b0;
    reading   = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      WRITE: begin
        wr_ready = 1'b1;
        writing  = 1'b1;
      end
      READ:    reading = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Address and beat counter; wraps modulo depth / burst range naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      cnt  <= '0;
    end else begin
      if (state == IDLE) begin
        if (req_valid) begin
          addr <= req_addr;
          cnt  <= req_len;
        end
      end else if (write_beat || read_beat) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 1'b1;
      end
    end
  end

  // RAM array is intentionally left out of reset
  always_ff @(posedge clock) begin
    if (write_beat) begin
      ram[addr] <= wr_data;
    end
  end

  // Registered read port; rd_data holds between beats
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= read_beat;
      rd_last  <= read_beat && last_beat;
      if (read_beat) begin
        rd_data <= ram[addr];
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_controller.sv
// Directed bench for ram_burst_controller with a read-beat scoreboard and a reference memory model.
module tb_ram_burst_controller;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int BW = 3;

  logic          clock;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          reading;
  logic          writing;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] model [2**AW];
  logic [DW:0]   exp_q [$];

  ram_burst_controller #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_WIDTH(BW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .reading  (reading),
    .writing  (writing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge; score any read beat
  task automatic tick();
    logic [DW:0] e;
    @(posedge clock);
    #1;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e[DW-1:0]);
        chk("rd_last", rd_last, e[DW]);
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] l);
    int n;
    logic [AW-1:0] idx;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_before_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
    if (w) begin
      chk("writing_after_accept", writing, 1);
    end else begin
      chk("reading_after_accept", reading, 1);
      for (int i = 0; i <= int'(l); i++) begin
        idx = a + AW'(i);
        exp_q.push_back({(i == int'(l)), model[idx]});
      end
    end
  endtask

  task automatic wr_beat(input logic [DW-1:0] d, input logic [AW-1:0] a);
    wr_valid = 1'b1;
    wr_data  = d;
    chk("writing_during_beat", writing, 1);
    tick();
    wr_valid = 1'b0;
    model[a] = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    for (int i = 0; i < 2**AW; i++) model[i] = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_reading", reading, 0);
    chk("rst_writing", writing, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    reset_n = 1'b1;
    tick();

    // 4-beat write at addr 3, then read it back
    do_req(1'b1, 4'd3, 3'd3);
    wr_beat(4'hA, 4'd3);
    wr_beat(4'hB, 4'd4);
    wr_beat(4'hC, 4'd5);
    wr_beat(4'hD, 4'd6);
    chk("wr_done_req_ready", req_ready, 1);
    chk("wr_done_writing", writing, 0);
    do_req(1'b0, 4'd3, 3'd3);
    drain();

    // Wrapping write across the top address, then read 0..1
    do_req(1'b1, 4'd14, 3'd3);
    wr_beat(4'h1, 4'd14);
    wr_beat(4'h2, 4'd15);
    wr_beat(4'h3, 4'd0);
    wr_beat(4'h4, 4'd1);
    do_req(1'b0, 4'd0, 3'd1);
    // Back-to-back: accepted in the IDLE cycle carrying rd_last
    do_req(1'b1, 4'd5, 3'd0);
    wr_beat(4'h7, 4'd5);
    drain();

    // Single-beat read latency at addr 5
    do_req(1'b0, 4'd5, 3'd0);
    chk("lat_no_early_valid", rd_valid, 0);
    tick();
    chk("lat_rd_valid", rd_valid, 1);
    chk("lat_rd_last", rd_last, 1);
    chk("lat_rd_data", rd_data, 4'h7);
    chk("lat_reading_off", reading, 0);
    chk("lat_req_ready", req_ready, 1);
    drain();

    // Stall: prefill 8..11 with F, then two beats with a 2-cycle gap
    do_req(1'b1, 4'd8, 3'd3);
    wr_beat(4'hF, 4'd8);
    wr_beat(4'hF, 4'd9);
    wr_beat(4'hF, 4'd10);
    wr_beat(4'hF, 4'd11);
    do_req(1'b1, 4'd8, 3'd1);
    wr_beat(4'h5, 4'd8);
    repeat (2) begin
      tick();
      chk("stall_writing", writing, 1);
      chk("stall_wr_ready", wr_ready, 1);
    end
    wr_beat(4'h6, 4'd9);
    chk("stall_done_req_ready", req_ready, 1);
    do_req(1'b0, 4'd8, 3'd3);
    drain();

    // Busy: read request pulsed mid-write is ignored
    do_req(1'b1, 4'd12, 3'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd0;
    req_len   = 3'd2;
    chk("busy_req_ready", req_ready, 0);
    tick();
    req_valid = 1'b0;
    chk("busy_writing", writing, 1);
    chk("busy_reading", reading, 0);
    wr_beat(4'h9, 4'd12);
    wr_beat(4'h8, 4'd13);
    repeat (3) begin
      chk("busy_no_rd_valid", rd_valid, 0);
      chk("busy_no_reading", reading, 0);
      tick();
    end

    // Reset during an 8-beat read from addr 0
    do_req(1'b0, 4'd0, 3'd7);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_last", rd_last, 0);
    chk("midrst_reading", reading, 0);
    chk("midrst_req_ready", req_ready, 1);
    exp_q.delete();
    #2;
    reset_n = 1'b1;
    do_req(1'b0, 4'd0, 3'd0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
